alu_test_sequencer: RTL
=======================

ALU_TEST_SEQUENCER -- requirements
Module: alu_test_sequencer

Interface
REQ-001 Parameter DW, 12, ALU operand width.
REQ-002 Parameter RW, 15, expected/actual result width.
REQ-003 Parameter FW, 4, function-select width.
REQ-004 Parameter AW, 4, vector ROM address width.
REQ-005 Parameter NUM_VEC, 16, vectors per run (1..2^AW).
REQ-006 Parameter LAT, 1, DUT result latency in cycles (0..7).
REQ-007 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-008 clock  in  1  rising-edge clock.
REQ-009 reset_n  in  1  asynchronous active-low reset.
REQ-010 start  in  1  single-cycle pulse that begins a run.
REQ-011 mode  in  1  0 = single-step, 1 = auto-run.
REQ-012 step  in  1  single-cycle pulse (debounced push-button) that advances in single-step mode.
REQ-013 vec_addr  out  AW  vector ROM read address.
REQ-014 a_in, b_in  in  DW  ROM operand data, registered ROM, valid 1 cycle after vec_addr.
REQ-015 funct_in  in  FW  ROM function data, same timing.
REQ-016 exp_in  in  RW  ROM expected result, same timing.
REQ-017 dut_a, dut_b  out  DW / dut_sel  out  FW  registered ALU stimulus.
REQ-018 dut_result  in  RW  ALU result, valid LAT cycles after stimulus changes.
REQ-019 mismatch  out  1  one-cycle pulse on a failing compare.
REQ-020 err_cnt  out  8  saturating mismatch count.
REQ-021 first_fail_addr  out  AW / fail_valid  out  1  address of first failing vector and its valid flag.
REQ-022 busy, done, pass  out  1  run status.

Function
REQ-023 FSM states SHALL be IDLE, FETCH, APPLY, WAIT, CHECK, HOLD, DONE.
REQ-024 IDLE or DONE + start: vec_addr<=0; err_cnt, fail_valid, first_fail_addr, done, pass cleared; go to FETCH.
REQ-025 start in any other state SHALL be ignored.
REQ-026 FETCH SHALL last 1 cycle, then go to APPLY.
REQ-027 APPLY: latch a_in, b_in, funct_in onto dut_a/dut_b/dut_sel and exp_in into an internal register; go to WAIT if LAT>0, else to CHECK.
REQ-028 WAIT SHALL last exactly LAT cycles, then go to CHECK.
REQ-029 CHECK SHALL compare dut_result with the latched expected value over all RW bits.
REQ-030 On mismatch in CHECK: pulse mismatch; err_cnt+1, saturating at 255; if fail_valid=0, capture vec_addr and set fail_valid.
REQ-031 After CHECK: if vec_addr==NUM_VEC-1, go to DONE; else if mode=1, vec_addr+1 and go to FETCH; else go to HOLD.
REQ-032 mode SHALL be sampled only in CHECK; changing it mid-run affects the next decision only.
REQ-033 HOLD + step: vec_addr+1 and go to FETCH; step outside HOLD SHALL be ignored.
REQ-034 DONE: done=1, pass=(err_cnt==0), busy=0; vec_addr, dut outputs and counters hold.
REQ-035 busy SHALL be 1 in every state except IDLE and DONE.
REQ-036 Auto-run cost SHALL be 3+LAT cycles per vector; done SHALL rise NUM_VEC*(3+LAT) cycles after the first FETCH cycle.

Reset
REQ-037 reset_n low SHALL force IDLE immediately, in any state including mid-run.
REQ-038 While reset_n is low, all outputs SHALL be 0: vec_addr, dut_a, dut_b, dut_sel, mismatch, err_cnt, first_fail_addr, fail_valid, busy, done, pass.
REQ-039 After release, the block SHALL stay in IDLE until start.

Verification
REQ-040 Auto-run, defaults, DUT model always matches -> done high 64 cycles after the first FETCH; err_cnt=0, pass=1, fail_valid=0.
REQ-041 Auto-run, mismatches injected at vectors 3 and 9 -> two mismatch pulses; err_cnt=2, first_fail_addr=3, fail_valid=1, pass=0.
REQ-042 mode=0, start -> parks in HOLD with vec_addr=0; 3 step pulses -> HOLD with vec_addr=3; step pulses during FETCH are ignored.
REQ-043 AW=9, NUM_VEC=300, every vector mismatches -> err_cnt stops at 255, first_fail_addr=0.
REQ-044 reset_n low at vector 5 of a run -> all outputs 0 asynchronously; next start restarts at vec_addr=0 with counters cleared.
REQ-045 start re-pulsed while busy -> no effect; start in DONE -> new run with err_cnt and done cleared.

Source files
------------

// File: rtl/alu_test_sequencer.sv
// Vector-driven ALU test sequencer: fetches operands/expected results from a registered ROM,
// drives the ALU, compares after LAT cycles and tracks errors, in auto-run or single-step mode.
module alu_test_sequencer #(
  parameter int DW      = 12,
  parameter int RW      = 15,
  parameter int FW      = 4,
  parameter int AW      = 4,
  parameter int NUM_VEC = 16,
  parameter int LAT     = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          mode,
  input  logic          step,
  output logic [AW-1:0] vec_addr,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic [FW-1:0] funct_in,
  input  logic [RW-1:0] exp_in,
  output logic [DW-1:0] dut_a,
  output logic [DW-1:0] dut_b,
  output logic [FW-1:0] dut_sel,
  input  logic [RW-1:0] dut_result,
  output logic          mismatch,
  output logic [7:0]    err_cnt,
  output logic [AW-1:0] first_fail_addr,
  output logic          fail_valid,
  output logic          busy,
  output logic          done,
  output logic          pass
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    APPLY = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    HOLD  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [AW-1:0] LAST   = AW'(NUM_VEC - 1);
  localparam logic [2:0]    LAT_M1 = 3'((LAT > 0) ? LAT - 1 : 0);

  state_t        state, state_nxt;
  logic [2:0]    wait_cnt;
  logic [RW-1:0] exp_q;
  logic          fail_now;

  assign fail_now = (dut_result != exp_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = FETCH;
      FETCH:      state_nxt = APPLY;
      APPLY:      state_nxt = (LAT > 0) ? WAIT : CHECK;
      WAIT:       if (wait_cnt == LAT_M1) state_nxt = CHECK;
      CHECK: begin
        if (vec_addr == LAST) state_nxt = DONE;
        else if (mode)        state_nxt = FETCH;
        else                  state_nxt = HOLD;
      end
      HOLD:       if (step) state_nxt = FETCH;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE) && (state != DONE);
    done = (state == DONE);
    pass = (state == DONE) && (err_cnt == 8'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vec_addr        <= '0;
      dut_a           <= '0;
      dut_b           <= '0;
      dut_sel         <= '0;
      exp_q           <= '0;
      wait_cnt        <= '0;
      mismatch        <= 1'b0;
      err_cnt         <= '0;
      first_fail_addr <= '0;
      fail_valid      <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          vec_addr        <= '0;
          err_cnt         <= '0;
          first_fail_addr <= '0;
          fail_valid      <= 1'b0;
        end
        APPLY: begin
          dut_a    <= a_in;
          dut_b    <= b_in;
          dut_sel  <= funct_in;
          exp_q    <= exp_in;
          wait_cnt <= '0;
        end
        WAIT: wait_cnt <= wait_cnt + 3'd1;
        CHECK: begin
          if (fail_now) begin
            mismatch <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (!fail_valid) begin
              first_fail_addr <= vec_addr;
              fail_valid      <= 1'b1;
            end
          end
          // mode is only consulted here, so a mid-run change affects just this decision
          if (vec_addr != LAST && mode) vec_addr <= vec_addr + AW'(1);
        end
        HOLD: if (step) vec_addr <= vec_addr + AW'(1);
        default: ;
      endcase
    end
  end

endmodule
